// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Entry rd width is fixed by HAZ_REG_AW; instantiate with REG_AW equal to it.
package hazard_pkg;

    localparam int unsigned HAZ_REG_AW = 5;
    localparam int unsigned FWD_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  load;
        logic [HAZ_REG_AW-1:0] rd;
    } haz_entry_t;

    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Decode-side request and hazard-control response bundle for pipe_hazard_unit.
interface pipe_hazard_unit_if #(
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned REG_AW       = hazard_pkg::HAZ_REG_AW,
    parameter int unsigned DEPTH        = 3
);
    localparam int unsigned SELW = hazard_pkg::sel_width(DEPTH);

    logic                           id_valid;
    logic [NUM_RD_PORTS*REG_AW-1:0] id_rs_addr;
    logic [NUM_RD_PORTS-1:0]        id_rs_used;
    logic [REG_AW-1:0]              id_rd_addr;
    logic                           id_rd_we;
    logic                           id_is_load;
    logic                           br_taken;
    logic [NUM_RD_PORTS*SELW-1:0]   fwd_sel;
    logic                           stall_fd;
    logic                           bubble_e;
    logic                           flush;

    modport master (
        output id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_we, id_is_load, br_taken,
        input  fwd_sel, stall_fd, bubble_e, flush
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_we, id_is_load, br_taken,
        output fwd_sel, stall_fd, bubble_e, flush
    );

endinterface

// File: rtl/fwd_match.sv
// Priority match of one source register against the in-flight stage entries.
// Youngest producer (lowest stage index) wins; load_hit_o flags a too-young load.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned REG_AW     = HAZ_REG_AW,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned SELW       = sel_width(DEPTH)
) (
    input  haz_entry_t [DEPTH:1] stages_i,
    input  logic [REG_AW-1:0]    addr_i,
    input  logic                 used_i,
    output logic [SELW-1:0]      sel_o,
    output logic                 load_hit_o
);

    always_comb begin
        sel_o      = SELW'(FWD_RF);
        load_hit_o = 1'b0;
        if (used_i && (addr_i != '0)) begin
            // Scan oldest to youngest so the youngest match is the one left standing.
            for (int k = DEPTH; k >= 1; k--) begin
                if (stages_i[k].valid && stages_i[k].we &&
                    (stages_i[k].rd == HAZ_REG_AW'(addr_i))) begin
                    sel_o      = SELW'(k);
                    load_hit_o = stages_i[k].load && (k < int'(LOAD_STAGE));
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: tracks in-flight destinations, selects forwarding
// sources, inserts load-use stalls and branch flushes. HAZ_PERF_EN adds perf counters.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned REG_AW       = HAZ_REG_AW,
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned LOAD_STAGE   = 2,
    parameter int unsigned BR_STAGE     = 2
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_unit_if.slave bus
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int unsigned SELW = sel_width(DEPTH);

    haz_entry_t [DEPTH:1]         stage_q, stage_d;
    logic [NUM_RD_PORTS-1:0]      load_hit;
    logic [NUM_RD_PORTS*SELW-1:0] fwd_sel_raw;
    logic                         stall_raw;
    logic                         flush_raw;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gen_port
        fwd_match #(
            .DEPTH      (DEPTH),
            .REG_AW     (REG_AW),
            .LOAD_STAGE (LOAD_STAGE),
            .SELW       (SELW)
        ) u_fwd_match (
            .stages_i   (stage_q),
            .addr_i     (bus.id_rs_addr[p*REG_AW +: REG_AW]),
            .used_i     (bus.id_rs_used[p]),
            .sel_o      (fwd_sel_raw[p*SELW +: SELW]),
            .load_hit_o (load_hit[p])
        );
    end

    // Flush wins over a simultaneous load-use stall.
    assign flush_raw = bus.br_taken;
    assign stall_raw = bus.id_valid && (|load_hit) && !flush_raw;

    assign bus.fwd_sel  = reset ? fwd_sel_raw : '0;
    assign bus.stall_fd = reset && stall_raw;
    assign bus.bubble_e = reset && stall_raw;
    assign bus.flush    = reset && flush_raw;

    always_comb begin
        stage_d = '0;
        if (bus.id_valid && !stall_raw && !flush_raw) begin
            stage_d[1].valid = 1'b1;
            stage_d[1].we    = bus.id_rd_we;
            stage_d[1].load  = bus.id_is_load;
            stage_d[1].rd    = HAZ_REG_AW'(bus.id_rd_addr);
        end
        for (int k = 2; k <= int'(DEPTH); k++) begin
            stage_d[k] = stage_q[k-1];
            // Wrong-path instructions behind the resolving branch are killed.
            if (flush_raw && (k <= int'(BR_STAGE))) begin
                stage_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_raw};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_raw};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the pipelined CPU. It tracks destination registers of in-flight instructions past Decode in an internal shift register, one entry per stage. It selects the forwarding source for every register-file read port and inserts load-use stalls. It generates branch flushes, so pipeline registers can be held or killed instead of always advancing.

## Interface
Parameters:
- NUM_RD_PORTS, 2, number of register read ports examined in Decode.
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after Decode (1 = E, 2 = M, 3 = W).
- LOAD_STAGE, 2, first stage whose result is forwardable for a load.
- BR_STAGE, 2, stage in which a taken branch is resolved.

Derived width:
- SELW = $clog2(DEPTH+1).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low.
- id_valid  input  1  instruction in Decode is valid.
- id_rs_addr  input  NUM_RD_PORTS*REG_AW  source register per port; port p occupies bits [p*REG_AW +: REG_AW].
- id_rs_used  input  NUM_RD_PORTS  port p actually reads its register.
- id_rd_addr  input  REG_AW  destination register of the Decode instruction.
- id_rd_we  input  1  Decode instruction writes the register file.
- id_is_load  input  1  Decode instruction is a load.
- br_taken  input  1  branch in stage BR_STAGE resolved taken this cycle.
- fwd_sel  output  NUM_RD_PORTS*SELW  per port: 0 = register file, k = result of stage k.
- stall_fd  output  1  hold PC, F/D and Decode outputs this cycle.
- bubble_e  output  1  load an invalid (all-zero control) entry into stage 1.
- flush  output  1  kill all instructions younger than stage BR_STAGE.

## Operation
Each tracked entry holds four fields: valid, we, load, rd. State is stage[1..DEPTH].

Forwarding, for each port p:
- Applies only when id_rs_used[p] is set and the address is nonzero.
- The match is the lowest k with stage[k].valid && stage[k].we && stage[k].rd == addr. The youngest producer wins.
- With a match, fwd_sel = k. With no match, or for register 0, fwd_sel = 0.

Load-use stall:
- Raised when any port's match k < LOAD_STAGE and stage[k].load is set.
- Also requires id_valid.
- Effect: stall_fd = bubble_e = 1.

Flush:
- flush = br_taken.
- Flush overrides stall: stall_fd = bubble_e = 0 when flush = 1.

Update on rising edge when reset is high:
- stage[k+1] <= stage[k] for all k.
- stage[1] <= Decode entry {id_valid, id_rd_we, id_is_load, id_rd_addr} if id_valid && !stall_fd && !flush; otherwise stage[1] <= invalid.
- On flush, every entry written into stages 2..BR_STAGE is also invalidated. These are wrong-path instructions.
- The branch entry moving from stage BR_STAGE to BR_STAGE+1 is preserved.

Multi-cycle stalls arise naturally when LOAD_STAGE > 2. The stall repeats until the load entry reaches stage LOAD_STAGE.

Entries with we = 0 never match.

## Timing
- All outputs are combinational from current state and Decode inputs. Latency is zero within the cycle.
- State advances one stage per clock. There is no back-pressure on stages ≥ 1.
- Reset: while reset = 0, stall_fd, bubble_e, flush and all fwd_sel fields are forced to 0. On a rising edge with reset = 0, all entries are cleared to invalid.
- Reset mid-stall or mid-flush aborts it. The first cycle after release has no hazards.
- A simultaneous load-use stall and br_taken produce flush only; stage[1] becomes invalid.
- stall_fd with id_valid = 0 never occurs.

## Configuration
- HAZ_PERF_EN defined: adds outputs perf_stall_cnt (output, 32 bits) and perf_flush_cnt (output, 32 bits).
  - Each counter increments by 1 on each rising edge where stall_fd, respectively flush, is 1.
  - Both wrap at 2^32 back to 0 and reset to 0.
- HAZ_PERF_EN undefined: these ports and counters do not exist, and there is no other change.

## Structure
- Package hazard_pkg holds the following shared definitions:
  - typedef haz_entry_t {valid, we, load, rd[REG_AW-1:0]}.
  - Constant FWD_RF = 0.
  - Helper function for SELW.
- Sub-module fwd_match, instantiated NUM_RD_PORTS times:
  - Takes the stage array, one address and its used bit.
  - Returns the priority match index k and a load-hit flag.

## Test plan
- Decode add $4,$3,$0 while stage[1] = {1,1,0,3} → fwd_sel port0 = 1, port1 = 0, stall_fd = 0.
- stage[1] = lw $5; Decode add $6,$5,$5 → stall_fd = bubble_e = 1 for one cycle, then fwd_sel = 2 on both ports and stall_fd = 0.
- stage[1] and stage[2] both write $7; Decode reads $7 → fwd_sel = 1. Decode reads $0 with stage[1] writing $0 → fwd_sel = 0.
- Load-use condition active and br_taken = 1 → flush = 1, stall_fd = 0. On the next cycle, stage[1] and stage[2] are invalid and stage[3] holds the branch entry.
- reset = 0 during a stall → all outputs 0 immediately. After release, Decode reading any register gives fwd_sel = 0. With HAZ_PERF_EN, perf_stall_cnt = 0.
- With HAZ_PERF_EN: three load-use stalls and two flushes → perf_stall_cnt = 3, perf_flush_cnt = 2.
